can_crc: RTL and testbench

CAN_CRC -- requirements
Module: can_crc

---
 rtl/can_crc.sv | 39 +++
 tb/tb_can_crc.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/can_crc.sv
// CAN frame CRC-15 generator/checker.
// Serial MSB-first LFSR, one bit absorbed per enabled clock.
module can_crc #(
  parameter int unsigned             CRC_WIDTH = 15,
  parameter logic [CRC_WIDTH-1:0]    CRC_POLY  = 15'h4599,
  parameter logic [CRC_WIDTH-1:0]    CRC_INIT  = 15'h0000
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 crc_en,
  input  logic                 data,
  output logic [CRC_WIDTH-1:0] crc_out
);

  logic [CRC_WIDTH-1:0] crc;
  logic [CRC_WIDTH-1:0] crc_nxt;
  logic                 fb;

  // feedback bit and next register value; the shifted-out MSB is dropped
  always_comb begin
    fb      = data ^ crc[CRC_WIDTH-1];
    crc_nxt = {crc[CRC_WIDTH-2:0], 1'b0};
    if (fb) begin
      crc_nxt = crc_nxt ^ CRC_POLY;
    end
  end

  // register: sync reset wins, otherwise shift only when enabled
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      crc <= CRC_INIT;
    end else if (crc_en) begin
      crc <= crc_nxt;
    end
  end

  assign crc_out = crc;

endmodule

// File: tb/tb_can_crc.sv
// Self-checking bench for can_crc.
// Expected values are queued at drive time and checked after the edge.
module tb_can_crc;

  logic        clk;
  logic        n_rst;
  logic        crc_en;
  logic        data;
  logic [14:0] crc_out;

  int n_chk;
  int n_err;

  typedef struct {
    string       tag;
    logic [14:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [14:0] mdl;

  can_crc dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .crc_en (crc_en),
    .data   (data),
    .crc_out(crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [14:0] got,
                     input logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // polynomial division with explicit x^15 term (16-bit form)
  function automatic logic [14:0] ref_step(input logic [14:0] c,
                                           input logic d);
    logic [15:0] v;
    v = {c, 1'b0};
    if (v[15] ^ d) v = v ^ 16'hC599;
    return v[14:0];
  endfunction

  // drive one clock, push model expectation, then pop/check after edge
  task automatic step(input logic rn, input logic en,
                      input logic d, input string tag);
    sb_t e;
    @(negedge clk);
    n_rst  = rn;
    crc_en = en;
    data   = d;
    if (!rn)     mdl = 15'h0000;
    else if (en) mdl = ref_step(mdl, d);
    e.tag = tag;
    e.exp = mdl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk(e.tag, crc_out, e.exp);
  endtask

  task automatic feed(input logic [31:0] w, input int n,
                      input string tag);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, w[i], tag);
  endtask

  logic [14:0] snap;
  logic [31:0] w;
  logic [14:0] c15;

  initial begin
    n_chk  = 0;
    n_err  = 0;
    mdl    = 15'h0000;
    n_rst  = 1'b1;
    crc_en = 1'b0;
    data   = 1'b0;

    // reset state, with enable and data active
    step(1'b0, 1'b1, 1'b1, "reset");
    chk("reset_val", crc_out, 15'h0000);

    // single 1 bit
    step(1'b1, 1'b1, 1'b1, "one_bit");
    chk("one_bit_const", crc_out, 15'h4599);

    // bits 1,0
    step(1'b0, 1'b0, 1'b0, "reset2");
    step(1'b1, 1'b1, 1'b1, "b10_a");
    chk("b10_a_const", crc_out, 15'h4599);
    step(1'b1, 1'b1, 1'b0, "b10_b");
    chk("b10_b_const", crc_out, 15'h4EAB);

    // 32 zero bits stay zero
    step(1'b0, 1'b0, 1'b0, "reset3");
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 1'b0, "zeros");
      chk("zeros_const", crc_out, 15'h0000);
    end

    // absorb word, then hold with random and X data
    step(1'b0, 1'b0, 1'b0, "reset4");
    feed(32'h80010085, 32, "w80010085");
    snap = mdl;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), "hold");
      chk("hold_snap", crc_out, snap);
    end
    step(1'b1, 1'b0, 1'bx, "hold_x");

    // message followed by its own CRC leaves zero
    step(1'b0, 1'b0, 1'b0, "reset5");
    feed(32'hFFFFFFFF, 32, "ones");
    c15 = mdl;
    w   = {17'd0, c15};
    feed(w, 15, "ones_crc");
    chk("residue_zero", crc_out, 15'h0000);

    // gapped enable matches consecutive absorption
    step(1'b0, 1'b0, 1'b0, "reset6");
    w = $urandom;
    for (int i = 31; i >= 0; i--) begin
      step(1'b1, 1'b1, w[i], "gap_bit");
      if ((i % 3) == 0) step(1'b1, 1'b0, ~w[i], "gap_idle");
    end
    snap = 15'h0000;
    for (int i = 31; i >= 0; i--) snap = ref_step(snap, w[i]);
    chk("gap_vs_cont", crc_out, snap);

    // mid-message reset with enable high, then restart from zero
    step(1'b0, 1'b0, 1'b0, "reset7");
    feed(32'hDEADBEEF, 16, "pre_rst");
    step(1'b0, 1'b1, 1'b1, "mid_rst");
    chk("mid_rst_zero", crc_out, 15'h0000);
    feed(32'h0000A5C3, 16, "post_rst");
    snap = 15'h0000;
    for (int i = 15; i >= 0; i--) snap = ref_step(snap, w[i] ^ w[i] ^ 1'(16'hA5C3 >> i));
    chk("post_rst_ref", crc_out, snap);

    if (sb_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_drain: got %0d expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
